// File: rtl/counter_pkg.sv
// Shared constants and helpers for the parametrised up/down counter family.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
package counter_pkg;

    // Behaviour at the range ends
    localparam int CNT_WRAP = 0;
    localparam int CNT_SAT  = 1;

    // Default highest count for a given width: 2**width - 1, computed wide
    // so that width = 32 does not overflow.
    function automatic longint default_max(input int width);
        return (longint'(1) << width) - 64'sd1;
    endfunction

    // Limit a value to the top of the counting range
    function automatic logic [31:0] clamp_max(input logic [31:0] val,
                                              input logic [31:0] max_val);
        return (val > max_val) ? max_val : val;
    endfunction

endpackage

// File: rtl/param_up_down_counter_step.sv
// Next-count computation for one enabled step, plus wrap / saturation events.
// Latency: purely combinational.
// Backpressure: none; result is valid whenever inputs are.
module counter_step
    import counter_pkg::*;
#(
    parameter int              WIDTH    = 8,
    parameter logic [WIDTH-1:0] MAX_VAL = '1,
    parameter int              SATURATE = CNT_WRAP
) (
    input  logic [WIDTH-1:0] cur_val,
    input  logic             up_down,
    input  logic             en,
    output logic [WIDTH-1:0] next_val,
    output logic             wrap_evt,
    output logic             sat_evt
);

    // Explicit range-end compares so non-power-of-two ranges wrap correctly
    always_comb begin
        next_val = cur_val;
        wrap_evt = 1'b0;
        sat_evt  = 1'b0;
        if (en) begin
            if (up_down) begin
                if (cur_val < MAX_VAL) begin
                    next_val = cur_val + WIDTH'(1);
                end else if (SATURATE == CNT_SAT) begin
                    sat_evt = 1'b1;
                end else begin
                    next_val = '0;
                    wrap_evt = 1'b1;
                end
            end else begin
                if (cur_val != '0) begin
                    next_val = cur_val - WIDTH'(1);
                end else if (SATURATE == CNT_SAT) begin
                    sat_evt = 1'b1;
                end else begin
                    next_val = MAX_VAL;
                    wrap_evt = 1'b1;
                end
            end
        end
    end

endmodule

// File: rtl/param_up_down_counter.sv
// Up/down counter with configurable width/modulus, wrap or saturate, clear and load.
// Latency: counter, wrap and sat_hit update one clk edge after inputs are sampled.
// Backpressure: none; every edge acts on the sampled controls (clear > load > en).
module param_up_down_counter
    import counter_pkg::*;
#(
    parameter int     WIDTH    = 8,
    parameter longint MAX_VAL  = default_max(WIDTH),
    parameter int     SATURATE = CNT_WRAP
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             clear,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    input  logic             en,
    input  logic             up_down,
    output logic [WIDTH-1:0] counter,
    output logic             at_max,
    output logic             at_min,
    output logic             wrap,
    output logic             sat_hit
);

    // Reject configurations the counter cannot represent
    if (WIDTH < 2 || WIDTH > 32) begin : g_bad_width
        $fatal(1, "param_up_down_counter: WIDTH must be 2..32");
    end
    if (MAX_VAL < 1 || MAX_VAL > default_max(WIDTH)) begin : g_bad_max
        $fatal(1, "param_up_down_counter: MAX_VAL must be 1..2**WIDTH-1");
    end
    if (SATURATE != CNT_WRAP && SATURATE != CNT_SAT) begin : g_bad_mode
        $fatal(1, "param_up_down_counter: SATURATE must be 0 or 1");
    end

    localparam logic [WIDTH-1:0] MAX_W = WIDTH'(MAX_VAL);

    logic [WIDTH-1:0] counter_q, counter_d;
    logic             wrap_q, wrap_d;
    logic             sat_hit_q, sat_hit_d;

    logic [WIDTH-1:0] step_val;
    logic             step_wrap;
    logic             step_sat;
    logic [WIDTH-1:0] load_clamped;

    counter_step #(
        .WIDTH    (WIDTH),
        .MAX_VAL  (MAX_W),
        .SATURATE (SATURATE)
    ) u_step (
        .cur_val  (counter_q),
        .up_down  (up_down),
        .en       (en),
        .next_val (step_val),
        .wrap_evt (step_wrap),
        .sat_evt  (step_sat)
    );

    // Loaded values above the range are pulled down to the top count
    always_comb begin
        load_clamped = WIDTH'(clamp_max(32'(load_val), 32'(MAX_W)));
    end

    // Priority mux: clear beats load beats counting; only counting raises events
    always_comb begin
        counter_d = counter_q;
        wrap_d    = 1'b0;
        sat_hit_d = 1'b0;
        if (clear) begin
            counter_d = '0;
        end else if (load) begin
            counter_d = load_clamped;
        end else begin
            counter_d = step_val;
            wrap_d    = step_wrap;
            sat_hit_d = step_sat;
        end
    end

    // State and event pulse registers
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            counter_q <= '0;
            wrap_q    <= 1'b0;
            sat_hit_q <= 1'b0;
        end else begin
            counter_q <= counter_d;
            wrap_q    <= wrap_d;
            sat_hit_q <= sat_hit_d;
        end
    end

    assign counter = counter_q;
    assign wrap    = wrap_q;
    assign sat_hit = sat_hit_q;
    assign at_max  = (counter_q == MAX_W);
    assign at_min  = (counter_q == '0);

endmodule

// File: tb/tb_param_up_down_counter.sv
// Self-checking bench: four counter configurations driven from shared controls.
// Latency: checks one edge after each stimulus; model compared every negedge.
// Backpressure: n/a.
module tb_param_up_down_counter;

    logic       clk = 1'b0;
    logic       reset;
    logic       clear, load, en, up_down;
    logic [7:0] load_val;

    logic [3:0] cnt_a, cnt_b;
    logic [7:0] cnt_c, cnt_d;
    logic [3:0] am, amn, wr, sh;

    int tests = 0;
    int fails = 0;
    bit chk_on = 1'b0;

    // Configurations: A 4b/15/wrap, B 4b/9/wrap, C 8b/200/sat, D 8b/200/wrap
    int maxv [4] = '{15, 9, 200, 200};
    int satm [4] = '{0, 0, 1, 0};
    int modv [4] = '{16, 16, 256, 256};

    int m_cnt  [4];
    bit m_wrap [4];
    bit m_sat  [4];

    always #5 clk = ~clk;

    param_up_down_counter #(.WIDTH(4), .MAX_VAL(15), .SATURATE(0)) u_a (
        .clk(clk), .reset(reset), .clear(clear), .load(load), .load_val(load_val[3:0]),
        .en(en), .up_down(up_down), .counter(cnt_a), .at_max(am[0]), .at_min(amn[0]),
        .wrap(wr[0]), .sat_hit(sh[0]));
    param_up_down_counter #(.WIDTH(4), .MAX_VAL(9), .SATURATE(0)) u_b (
        .clk(clk), .reset(reset), .clear(clear), .load(load), .load_val(load_val[3:0]),
        .en(en), .up_down(up_down), .counter(cnt_b), .at_max(am[1]), .at_min(amn[1]),
        .wrap(wr[1]), .sat_hit(sh[1]));
    param_up_down_counter #(.WIDTH(8), .MAX_VAL(200), .SATURATE(1)) u_c (
        .clk(clk), .reset(reset), .clear(clear), .load(load), .load_val(load_val),
        .en(en), .up_down(up_down), .counter(cnt_c), .at_max(am[2]), .at_min(amn[2]),
        .wrap(wr[2]), .sat_hit(sh[2]));
    param_up_down_counter #(.WIDTH(8), .MAX_VAL(200), .SATURATE(0)) u_d (
        .clk(clk), .reset(reset), .clear(clear), .load(load), .load_val(load_val),
        .en(en), .up_down(up_down), .counter(cnt_d), .at_max(am[3]), .at_min(amn[3]),
        .wrap(wr[3]), .sat_hit(sh[3]));

    function automatic int gcnt(input int i);
        case (i)
            0:       return int'(cnt_a);
            1:       return int'(cnt_b);
            2:       return int'(cnt_c);
            default: return int'(cnt_d);
        endcase
    endfunction

    // Model: signed integer step, out-of-range result means an end was crossed
    function automatic int stepped(input int cur);
        return up_down ? cur + 1 : cur - 1;
    endfunction

    function automatic bit crosses(input int cur, input int i);
        int t;
        t = stepped(cur);
        return (t < 0) || (t > maxv[i]);
    endfunction

    function automatic bit counting();
        return !clear && !load && en;
    endfunction

    function automatic int nxt_cnt(input int cur, input int i);
        int lv;
        int t;
        if (clear) return 0;
        if (load) begin
            lv = int'(load_val) % modv[i];
            return (lv > maxv[i]) ? maxv[i] : lv;
        end
        if (!en) return cur;
        t = stepped(cur);
        if (!crosses(cur, i)) return t;
        if (satm[i] != 0) return cur;
        return (t < 0) ? maxv[i] : 0;
    endfunction

    // Reference model state, updated on the same events as the design
    always @(posedge clk or posedge reset) begin
        for (int i = 0; i < 4; i++) begin
            if (reset) begin
                m_cnt[i]  <= 0;
                m_wrap[i] <= 1'b0;
                m_sat[i]  <= 1'b0;
            end else begin
                m_cnt[i]  <= nxt_cnt(m_cnt[i], i);
                m_wrap[i] <= counting() && crosses(m_cnt[i], i) && (satm[i] == 0);
                m_sat[i]  <= counting() && crosses(m_cnt[i], i) && (satm[i] != 0);
            end
        end
    end

    task automatic check(input string name, input int act, input int exp);
        tests++;
        if (act != exp) begin
            fails++;
            $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Every-cycle comparison against the model
    always @(negedge clk) begin
        if (chk_on) begin
            for (int i = 0; i < 4; i++) begin
                check($sformatf("model_cnt%0d", i),  gcnt(i),      m_cnt[i]);
                check($sformatf("model_max%0d", i),  int'(am[i]),  int'(m_cnt[i] == maxv[i]));
                check($sformatf("model_min%0d", i),  int'(amn[i]), int'(m_cnt[i] == 0));
                check($sformatf("model_wrap%0d", i), int'(wr[i]),  int'(m_wrap[i]));
                check($sformatf("model_sat%0d", i),  int'(sh[i]),  int'(m_sat[i]));
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        reset = 1'b1; clear = 1'b0; load = 1'b0; en = 1'b0; up_down = 1'b0; load_val = 8'd0;
        step(); step();
        chk_on = 1'b1;
        check("rst_cnt_a", int'(cnt_a), 0);
        check("rst_min_a", int'(amn[0]), 1);
        check("rst_max_a", int'(am[0]), 0);
        check("rst_wrap", int'(wr), 0);
        check("rst_sat", int'(sh), 0);
        reset = 1'b0;

        // Count up 17 edges: A 1..15, 0 (wrap), 1; B wraps 9->0 on edge 10
        en = 1'b1; up_down = 1'b1;
        for (int k = 1; k <= 17; k++) begin
            step();
            if (k <= 15) check("up_a", int'(cnt_a), k);
            if (k == 15) check("up_a_atmax", int'(am[0]), 1);
            if (k == 16) begin
                check("up_a_wrapcnt", int'(cnt_a), 0);
                check("up_a_wrap", int'(wr[0]), 1);
            end else begin
                check("up_a_nowrap", int'(wr[0]), 0);
            end
            if (k == 17) check("up_a_after", int'(cnt_a), 1);
            if (k == 10) begin
                check("up_b_wrapcnt", int'(cnt_b), 0);
                check("up_b_wrap", int'(wr[1]), 1);
            end
        end

        // Clear, then count down from 0: wrap to max / saturate at 0
        en = 1'b0; clear = 1'b1;
        step();
        check("clr_c", int'(cnt_c), 0);
        clear = 1'b0; en = 1'b1; up_down = 1'b0;
        step();
        check("dn_a", int'(cnt_a), 15);
        check("dn_b", int'(cnt_b), 9);
        check("dn_b_wrap", int'(wr[1]), 1);
        check("dn_c", int'(cnt_c), 0);
        check("dn_c_sat", int'(sh[2]), 1);
        check("dn_d", int'(cnt_d), 200);
        check("dn_d_wrap", int'(wr[3]), 1);
        for (int k = 1; k <= 10; k++) begin
            step();
            check("dn_b_seq", int'(cnt_b), (k <= 9) ? 9 - k : 9);
            check("dn_b_seq_wrap", int'(wr[1]), (k == 10) ? 1 : 0);
            check("dn_c_sat_run", int'(sh[2]), 1);
        end

        // Load 199 then count up into saturation on C
        en = 1'b0; load = 1'b1; load_val = 8'd199;
        step();
        check("ld_c", int'(cnt_c), 199);
        check("ld_a", int'(cnt_a), 7);
        load = 1'b0; en = 1'b1; up_down = 1'b1;
        step();
        check("sat_c1", int'(cnt_c), 200);
        check("sat_c1_hit", int'(sh[2]), 0);
        check("sat_c1_max", int'(am[2]), 1);
        check("sat_d1", int'(cnt_d), 200);
        step();
        check("sat_c2", int'(cnt_c), 200);
        check("sat_c2_hit", int'(sh[2]), 1);
        check("sat_d2", int'(cnt_d), 0);
        check("sat_d2_wrap", int'(wr[3]), 1);
        step();
        check("sat_c3", int'(cnt_c), 200);
        check("sat_c3_hit", int'(sh[2]), 1);
        check("sat_d3", int'(cnt_d), 1);

        // Out-of-range load clamps; clear overrides load and en
        en = 1'b0; load = 1'b1; load_val = 8'd250;
        step();
        check("clamp_c", int'(cnt_c), 200);
        check("clamp_b", int'(cnt_b), 9);
        check("clamp_a", int'(cnt_a), 10);
        check("clamp_c_nosat", int'(sh[2]), 0);
        clear = 1'b1; en = 1'b1; up_down = 1'b1;
        step();
        check("prio_d", int'(cnt_d), 0);
        check("prio_c", int'(cnt_c), 0);
        check("prio_wrap", int'(wr), 0);
        check("prio_sat", int'(sh), 0);

        // Count to 5, then asynchronous reset between edges
        clear = 1'b0; load = 1'b0;
        repeat (5) step();
        check("pre_rst_a", int'(cnt_a), 5);
        #3;
        reset = 1'b1;
        #1;
        check("async_rst_a", int'(cnt_a), 0);
        check("async_rst_c", int'(cnt_c), 0);
        check("async_rst_min", int'(amn[0]), 1);
        step();
        check("rst_hold_a", int'(cnt_a), 0);
        reset = 1'b0; up_down = 1'b0;
        step();
        check("post_rst_a", int'(cnt_a), 15);
        check("post_rst_a_wrap", int'(wr[0]), 1);
        check("post_rst_b", int'(cnt_b), 9);

        // Toggle direction each edge from 7, then hold with en=0
        en = 1'b0; load = 1'b1; load_val = 8'd7;
        step();
        load = 1'b0; en = 1'b1;
        for (int k = 0; k < 4; k++) begin
            up_down = (k % 2 == 0);
            step();
            check("tog_a", int'(cnt_a), (k % 2 == 0) ? 8 : 7);
            check("tog_c", int'(cnt_c), (k % 2 == 0) ? 8 : 7);
        end
        en = 1'b0;
        repeat (3) begin
            step();
            check("hold_a", int'(cnt_a), 7);
            check("hold_d", int'(cnt_d), 7);
            check("hold_wrap", int'(wr), 0);
            check("hold_sat", int'(sh), 0);
        end

        @(negedge clk);
        chk_on = 1'b0;
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
